// File: rtl/spi_master_pkg.sv
// ============================================================================
// spi_master_pkg : shared SPI master constants and receiver state type
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_master_pkg;

    localparam int SPI_WORD_W        = 32;
    localparam int SPI_RX_FIFO_DEPTH = 8;

    // Receiver shifter states; WAIT_FIFO* are the stalls caused by a full RX FIFO.
    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        RECEIVE        = 2'd1,
        WAIT_FIFO      = 2'd2,
        WAIT_FIFO_DONE = 2'd3
    } spi_rx_state_e;

endpackage : spi_master_pkg

`default_nettype wire

// File: rtl/spi_master_rx_fifo.sv
// ============================================================================
// spi_master_rx_fifo : first-word-fall-through receive word buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_master_rx_fifo
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_WORD_W,
    parameter int DEPTH      = SPI_RX_FIFO_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CNT_WIDTH-1:0]  elements_o,
    output logic                  full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Occupancy alone decides empty/full, so pointers may wrap freely.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = valid_i && !w_full;
    assign w_pop   = ready_i && !w_empty;

    assign ready_o    = !w_full;
    assign full_o     = w_full;
    assign valid_o    = !w_empty;
    assign elements_o = r_count;
    assign data_o     = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is not reset; an empty FIFO masks it on data_o.
    always_ff @(posedge clk) begin
        if (!rst && !clr_i && w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule : spi_master_rx_fifo

`default_nettype wire

// File: tb/tb_spi_master_rx_fifo.sv
// ============================================================================
// tb_spi_master_rx_fifo : directed self-checking bench for spi_master_rx_fifo
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_master_rx_fifo;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_i;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] elements_o;
    logic          full_o;

    int total = 0;
    int bad   = 0;

    spi_master_rx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .elements_o (elements_o),
        .full_o     (full_o)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_elems"}, 32'(elements_o), 32'd0);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_full"},  32'(full_o), 32'd0);
        chk({tag, "_data"},  data_o, 32'd0);
    endtask

    task automatic fill_1_to_8();
        ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            valid_i = 1'b1;
            data_i  = 32'(i);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; clr_i = 1'b0; data_i = '0; valid_i = 1'b0; ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_empty("reset");

        // Pops on an empty FIFO are ignored.
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_pop_elems", 32'(elements_o), 32'd0);
            chk("idle_pop_valid", 32'(valid_o), 32'd0);
        end

        // Push into empty with ready_i high: no same-cycle bypass.
        valid_i = 1'b1; data_i = 32'hA5A5_0001;
        step();
        valid_i = 1'b0;
        chk("fwft_valid", 32'(valid_o), 32'd1);
        chk("fwft_data",  data_o, 32'hA5A5_0001);
        chk("fwft_elems", 32'(elements_o), 32'd1);
        step();
        chk_empty("fwft_popped");

        // Fill to full, then an ignored 9th push.
        fill_1_to_8();
        chk("full_flag",  32'(full_o), 32'd1);
        chk("full_ready", 32'(ready_o), 32'd0);
        chk("full_elems", 32'(elements_o), 32'd8);
        data_i = 32'h9;
        step();
        valid_i = 1'b0;
        chk("ovf_elems", 32'(elements_o), 32'd8);
        chk("ovf_head",  data_o, 32'd1);
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", data_o, 32'(i));
            step();
        end
        chk_empty("drained");

        // Full with pop and push in the same cycle: push refused.
        fill_1_to_8();
        valid_i = 1'b1; data_i = 32'h9; ready_i = 1'b1;
        step();
        chk("fullpop_elems", 32'(elements_o), 32'd7);
        chk("fullpop_ready", 32'(ready_o), 32'd1);
        chk("fullpop_head",  data_o, 32'd2);
        ready_i = 1'b0;
        step();
        valid_i = 1'b0;
        chk("late_push_elems", 32'(elements_o), 32'd8);
        ready_i = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            chk("fullpop_order", data_o, 32'(i));
            step();
        end
        chk_empty("fullpop_drained");

        // Steady state at occupancy 3 across pointer wrap.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; data_i = 32'h100 + 32'(i);
            step();
        end
        chk("steady_pre_elems", 32'(elements_o), 32'd3);
        for (int k = 0; k < 20; k++) begin
            valid_i = 1'b1; ready_i = 1'b1; data_i = 32'h103 + 32'(k);
            chk("steady_data", data_o, 32'h100 + 32'(k));
            step();
            chk("steady_elems", 32'(elements_o), 32'd3);
        end
        valid_i = 1'b0; ready_i = 1'b0;

        // Flush at occupancy 5 with concurrent push and pop.
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1; data_i = 32'h200 + 32'(i);
            step();
        end
        valid_i = 1'b0;
        chk("pre_clr_elems", 32'(elements_o), 32'd5);
        clr_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 32'hDEAD_0001;
        step();
        clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        chk_empty("clr");
        step();
        chk_empty("clr_hold");

        // Pointers restart cleanly after the flush.
        valid_i = 1'b1; data_i = 32'h0000_CAFE;
        step();
        valid_i = 1'b0;
        chk("post_clr_data",  data_o, 32'h0000_CAFE);
        chk("post_clr_elems", 32'(elements_o), 32'd1);

        // Same scenario using reset.
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = 32'h300 + 32'(i);
            step();
        end
        valid_i = 1'b0;
        chk("pre_rst_elems", 32'(elements_o), 32'd5);
        rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 32'hDEAD_0002;
        step();
        rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        chk_empty("rst_mid");
        step();
        chk_empty("rst_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_master_rx_fifo

`default_nettype wire
